audio_clip_player: RTL and testbench

- Downstream playback stage driven by the game's audio-control FSM.
- Takes a clip request (`en` + `audio_select`) and fetches 8-bit unsigned samples from a synchronous sample ROM at a fixed sample rate.
- Converts each sample to PWM on both speaker pins.
- Signals end of clip with a one-cycle `playback_complete` pulse, which the control FSM uses to return to idle or lock out further sounds.

---
 rtl/audio_pkg.sv | 30 +++
 rtl/pwm_modulator.sv | 28 ++
 rtl/audio_clip_player.sv | 133 +++++++++++++
 tb/tb_audio_clip_player.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Clip table and shared types for the audio clip player.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: clip_id_t, player_state_t, CLIP_BASE/CLIP_LEN tables indexed by clip ID.
// The tables are regenerated together with the sample ROM .coe/.mem image.
package audio_pkg;

  typedef enum logic [1:0] {
    CLIP_NONE = 2'b00,
    CLIP_JUMP = 2'b01,
    CLIP_DEAD = 2'b10,
    CLIP_WIN  = 2'b11
  } clip_id_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4,
    ST_REARM = 3'd5
  } player_state_t;

  localparam int CLIP_TABLE_W = 16;

  // Entry [i] belongs to clip ID i (entry 3 is the MSB word).
  localparam logic [3:0][CLIP_TABLE_W-1:0] CLIP_BASE = {16'h0200, 16'h0100, 16'h0010, 16'h0000};
  localparam logic [3:0][CLIP_TABLE_W-1:0] CLIP_LEN  = {16'd4,    16'd2,    16'd3,    16'd0};

endpackage

// File: rtl/pwm_modulator.sv
// PWM stage: free-running counter compared against the current sample.
// Latency: 1 cycle from duty/active to pwm_out (registered compare).
// Backpressure: none; counter runs every cycle regardless of active.
// Ports: Clk, reset_rtl_0 (sync active-low), active (gate), duty (sample), pwm_out.
module pwm_modulator #(
  parameter int SAMPLE_W = 8
) (
  input  logic                Clk,
  input  logic                reset_rtl_0,
  input  logic                active,
  input  logic [SAMPLE_W-1:0] duty,
  output logic                pwm_out
);

  logic [SAMPLE_W-1:0] pwm_cnt;

  always_ff @(posedge Clk) begin
    if (!reset_rtl_0) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + SAMPLE_W'(1);
      // Strict less-than: duty 0 is always low, full scale is high 255 of 256.
      pwm_out <= active && (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/audio_clip_player.sv
// Plays a selected clip from a synchronous sample ROM as PWM on both speaker pins.
// Latency: first ROM address 1 edge after en; completion pulse L*CLK_DIV edges after start (1 for silence).
// Backpressure: none; en is a level request, dropping it mid-clip aborts without a completion pulse.
// Ports: Clk, reset_rtl_0 (sync active-low), en, audio_select, rom_addr/rom_data,
//        leftsound/rightsound (same PWM signal), playback_complete (one-cycle pulse).
module audio_clip_player
  import audio_pkg::*;
#(
  parameter int CLK_DIV  = 12500,
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 16
) (
  input  logic                Clk,
  input  logic                reset_rtl_0,
  input  logic                en,
  input  logic [1:0]          audio_select,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic                leftsound,
  output logic                rightsound,
  output logic                playback_complete
);

  localparam int TICK_W = $clog2(CLK_DIV);

  player_state_t           state;
  clip_id_t                sel_q;
  clip_id_t                sel_live;
  logic [CLIP_TABLE_W-1:0] idx_q;
  logic [CLIP_TABLE_W-1:0] idx_nxt;
  logic [TICK_W-1:0]       tick_q;
  logic [SAMPLE_W-1:0]     sample_reg;
  logic                    pwm_active;
  logic                    pwm_out;

  assign sel_live = clip_id_t'(audio_select);
  assign idx_nxt  = idx_q + CLIP_TABLE_W'(1);

  // FETCH of the very first sample has no sample loaded yet; later FETCH
  // cycles keep playing the previous sample so the period stays seamless.
  assign pwm_active = (state == ST_WAIT) || (state == ST_PLAY) ||
                      ((state == ST_FETCH) && (idx_q != '0));

  assign playback_complete = (state == ST_DONE);

  always_ff @(posedge Clk) begin
    if (!reset_rtl_0) begin
      state      <= ST_IDLE;
      sel_q      <= CLIP_NONE;
      idx_q      <= '0;
      tick_q     <= '0;
      sample_reg <= '0;
      rom_addr   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          sample_reg <= '0;
          if (en) begin
            sel_q <= sel_live;
            idx_q <= '0;
            if (CLIP_LEN[sel_live] == '0) begin
              state <= ST_DONE;
            end else begin
              // Address is registered on entry so it is stable for the whole FETCH cycle.
              rom_addr <= ADDR_W'(CLIP_BASE[sel_live]);
              state    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (!en) begin
            state      <= ST_IDLE;
            sample_reg <= '0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!en) begin
            state      <= ST_IDLE;
            sample_reg <= '0;
          end else begin
            sample_reg <= rom_data;
            // FETCH and WAIT already used 2 cycles; PLAY runs CLK_DIV-3 down to 0.
            tick_q     <= TICK_W'(CLK_DIV - 3);
            state      <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (!en) begin
            state      <= ST_IDLE;
            sample_reg <= '0;
          end else if (tick_q == '0) begin
            idx_q <= idx_nxt;
            if (idx_nxt == CLIP_LEN[sel_q]) begin
              state <= ST_DONE;
            end else begin
              rom_addr <= ADDR_W'(CLIP_BASE[sel_q]) + ADDR_W'(idx_nxt);
              state    <= ST_FETCH;
            end
          end else begin
            tick_q <= tick_q - TICK_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_REARM;
        end
        ST_REARM: begin
          if (!en) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  pwm_modulator #(
    .SAMPLE_W(SAMPLE_W)
  ) u_pwm (
    .Clk        (Clk),
    .reset_rtl_0(reset_rtl_0),
    .active     (pwm_active),
    .duty       (sample_reg),
    .pwm_out    (pwm_out)
  );

  assign leftsound  = pwm_out;
  assign rightsound = pwm_out;

endmodule

// File: tb/tb_audio_clip_player.sv
// Directed bench for audio_clip_player with CLK_DIV=4 and a behavioural sync ROM.
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_clip_player;

  logic        Clk;
  logic        reset_rtl_0;
  logic        en;
  logic [1:0]  audio_select;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        leftsound;
  logic        rightsound;
  logic        playback_complete;

  int n_checks;
  int n_fail;

  // Reference PWM counter: free-running, cleared by the synchronous reset.
  logic [7:0] cnt_m;

  audio_clip_player #(
    .CLK_DIV (4),
    .SAMPLE_W(8),
    .ADDR_W  (16)
  ) dut (
    .Clk              (Clk),
    .reset_rtl_0      (reset_rtl_0),
    .en               (en),
    .audio_select     (audio_select),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .leftsound        (leftsound),
    .rightsound       (rightsound),
    .playback_complete(playback_complete)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    case (a)
      16'h0010: rom_fn = 8'h00;
      16'h0011: rom_fn = 8'h80;
      16'h0012: rom_fn = 8'hFF;
      16'h0100: rom_fn = 8'h40;
      16'h0101: rom_fn = 8'hC0;
      16'h0200: rom_fn = 8'h20;
      16'h0201: rom_fn = 8'h60;
      16'h0202: rom_fn = 8'hA0;
      16'h0203: rom_fn = 8'hE0;
      default:  rom_fn = 8'h5A;
    endcase
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  always @(posedge Clk) begin
    if (!reset_rtl_0) cnt_m <= 8'd0;
    else              cnt_m <= cnt_m + 8'd1;
  end

  // Jump clip schedule, m = edges after the start edge (0 = start edge).
  function automatic logic jump_act(input int m);
    jump_act = (m >= 1) && (m <= 11);
  endfunction

  function automatic logic [7:0] jump_samp(input int m);
    if (m < 6)       jump_samp = 8'h00;
    else if (m < 10) jump_samp = 8'h80;
    else             jump_samp = 8'hFF;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    reset_rtl_0  = 1'b0;
    en           = 1'b1;
    audio_select = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (rom_addr !== 16'h0000 || leftsound !== 1'b0 || rightsound !== 1'b0 || playback_complete !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: addr=%h l=%b r=%b pc=%b, want 0000 0 0 0",
                 i, rom_addr, leftsound, rightsound, playback_complete);
      end
    end
    reset_rtl_0 = 1'b1;
    tick();
    n_checks++;
    if (rom_addr !== 16'h0010 || playback_complete !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_start: addr=%h pc=%b, want 0010 0", rom_addr, playback_complete);
    end
    en = 1'b0;
    tick();
    tick();
    n_checks++;
    if (leftsound !== 1'b0 || playback_complete !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_quiet: l=%b pc=%b, want 0 0", leftsound, playback_complete);
    end
  endtask

  task automatic test_jump_clip();
    logic [15:0] exp_addr;
    logic        exp_pwm;
    logic [7:0]  c_prev;
    audio_select = 2'b01;
    en           = 1'b1;
    for (int n = 0; n <= 13; n++) begin
      c_prev = cnt_m;
      tick();
      exp_addr = (n < 4) ? 16'h0010 : (n < 8) ? 16'h0011 : 16'h0012;
      exp_pwm  = jump_act(n - 1) && (c_prev < jump_samp(n - 1));
      n_checks++;
      if (rom_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL jump_addr n=%0d: got %h want %h", n, rom_addr, exp_addr);
      end
      n_checks++;
      if (playback_complete !== (n == 12)) begin
        n_fail++;
        $display("FAIL jump_complete n=%0d: got %b want %b", n, playback_complete, (n == 12));
      end
      n_checks++;
      if (leftsound !== exp_pwm || rightsound !== exp_pwm) begin
        n_fail++;
        $display("FAIL jump_pwm n=%0d cnt=%0d: got l=%b r=%b want %b",
                 n, c_prev, leftsound, rightsound, exp_pwm);
      end
    end
  endtask

  task automatic test_rearm();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (playback_complete !== 1'b0 || rom_addr !== 16'h0012 || leftsound !== 1'b0) begin
        n_fail++;
        $display("FAIL rearm_hold i=%0d: pc=%b addr=%h l=%b, want 0 0012 0",
                 i, playback_complete, rom_addr, leftsound);
      end
    end
    en = 1'b0;
    tick();
    audio_select = 2'b10;
    en           = 1'b1;
    tick();
    n_checks++;
    if (rom_addr !== 16'h0100) begin
      n_fail++;
      $display("FAIL dead_start: got %h want 0100", rom_addr);
    end
    for (int n = 1; n <= 9; n++) begin
      tick();
      n_checks++;
      if (rom_addr !== ((n < 4) ? 16'h0100 : 16'h0101) || playback_complete !== (n == 8)) begin
        n_fail++;
        $display("FAIL dead_clip n=%0d: addr=%h pc=%b want %h %b", n, rom_addr,
                 playback_complete, (n < 4) ? 16'h0100 : 16'h0101, (n == 8));
      end
    end
    en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    audio_select = 2'b01;
    en           = 1'b1;
    for (int n = 0; n <= 6; n++) begin
      tick();
      n_checks++;
      if (playback_complete !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_pre n=%0d: pc=%b want 0", n, playback_complete);
      end
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (playback_complete !== 1'b0 || rom_addr !== 16'h0011) begin
      n_fail++;
      $display("FAIL abort_edge: pc=%b addr=%h want 0 0011", playback_complete, rom_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (leftsound !== 1'b0 || rightsound !== 1'b0 || playback_complete !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet i=%0d: l=%b r=%b pc=%b want 0 0 0",
                 i, leftsound, rightsound, playback_complete);
      end
    end
    // An immediate restart proves the FSM went to IDLE, not REARM.
    audio_select = 2'b11;
    en           = 1'b1;
    tick();
    n_checks++;
    if (rom_addr !== 16'h0200) begin
      n_fail++;
      $display("FAIL abort_restart: got %h want 0200", rom_addr);
    end
    en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_silence();
    audio_select = 2'b00;
    en           = 1'b1;
    tick();
    n_checks++;
    if (playback_complete !== 1'b1 || rom_addr !== 16'h0200 || leftsound !== 1'b0) begin
      n_fail++;
      $display("FAIL silence_pulse: pc=%b addr=%h l=%b want 1 0200 0",
               playback_complete, rom_addr, leftsound);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (playback_complete !== 1'b0 || rom_addr !== 16'h0200 || leftsound !== 1'b0) begin
        n_fail++;
        $display("FAIL silence_after i=%0d: pc=%b addr=%h l=%b want 0 0200 0",
                 i, playback_complete, rom_addr, leftsound);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_mid_clip();
    logic [15:0] exp_addr;
    audio_select = 2'b01;
    en           = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      tick();
      exp_addr = (n < 4) ? 16'h0010 : (n < 8) ? 16'h0011 : 16'h0012;
      n_checks++;
      if (rom_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL midclip_addr n=%0d: got %h want %h", n, rom_addr, exp_addr);
      end
      if (n == 4) audio_select = 2'b11;
    end
    reset_rtl_0 = 1'b0;
    tick();
    n_checks++;
    if (rom_addr !== 16'h0000 || leftsound !== 1'b0 || rightsound !== 1'b0 || playback_complete !== 1'b0) begin
      n_fail++;
      $display("FAIL midclip_reset: addr=%h l=%b r=%b pc=%b want 0000 0 0 0",
               rom_addr, leftsound, rightsound, playback_complete);
    end
    en          = 1'b0;
    reset_rtl_0 = 1'b1;
    tick();
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_rtl_0  = 1'b0;
    en           = 1'b0;
    audio_select = 2'b00;
    test_reset();
    test_jump_clip();
    test_rearm();
    test_abort();
    test_silence();
    test_mid_clip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
